// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// Module   : rob_pkg
// Purpose  : Shared ROB sizing constants, tag type and controller state enum.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rob_pkg;
  localparam int ROB   = 2;
  localparam int DEPTH = 2 ** (ROB + 1);

  typedef logic [ROB:0] tag_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;
endpackage

`default_nettype wire

// File: rtl/rob_ptr.sv
// ---------------------------------------------------------------------------
// Module   : rob_ptr
// Purpose  : Modulo-2^W pointer with increment enable and synchronous clear.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Clear wins over increment; natural binary overflow gives the wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/rob_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : rob_alloc_ctrl
// Purpose  : Reorder-buffer allocation/commit pointer and occupancy control.
//            Optional macro ROB_ALLOC_PERF_EN adds a full-stall cycle counter.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rob_alloc_ctrl #(
  parameter int ROB = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           alloc_req,
  input  logic           commit_valid,
  input  logic           flush,
  output logic [ROB:0]   alloc_tag,
  output logic           alloc_grant,
  output logic           rob_full,
  output logic           rob_empty,
  output logic [ROB:0]   commit_tag,
  output logic [ROB+1:0] free_count
`ifdef ROB_ALLOC_PERF_EN
  ,
  output logic [15:0]    full_cycles
`endif
);

  import rob_pkg::*;

  localparam logic [ROB+1:0] C_DEPTH = (ROB + 2)'(2 ** (ROB + 1));

  state_e         r_state;
  state_e         w_state_nxt;
  logic [ROB+1:0] r_count;
  logic [ROB+1:0] w_count_nxt;
  logic [ROB:0]   w_head;
  logic [ROB:0]   w_tail;
  logic           w_full;
  logic           w_empty;
  logic           w_grant;
  logic           w_commit;

  assign w_full   = (r_count == C_DEPTH) || (r_state == FLUSH);
  assign w_empty  = (r_count == '0);
  // Full is sampled from registers, so a same-cycle commit cannot open a slot.
  assign w_grant  = alloc_req & ~w_full & ~flush;
  assign w_commit = commit_valid & ~w_empty & ~flush;

  rob_ptr #(.W(ROB + 1)) u_tail (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (flush),
    .i_inc   (w_grant),
    .o_ptr   (w_tail)
  );

  rob_ptr #(.W(ROB + 1)) u_head (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (flush),
    .i_inc   (w_commit),
    .o_ptr   (w_head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = RUN;
    w_count_nxt = r_count;
    if (flush) begin
      w_state_nxt = FLUSH;
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + (ROB + 2)'(w_grant) - (ROB + 2)'(w_commit);
    end
  end

`ifdef ROB_ALLOC_PERF_EN
  logic [15:0] r_full_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full_cycles <= '0;
    end else if (alloc_req && w_full && (r_full_cycles != 16'hFFFF)) begin
      r_full_cycles <= r_full_cycles + 16'd1;
    end
  end

  assign full_cycles = r_full_cycles;
`endif

  assign alloc_tag   = w_tail;
  assign commit_tag  = w_head;
  assign alloc_grant = w_grant;
  assign rob_full    = w_full;
  assign rob_empty   = w_empty;
  assign free_count  = C_DEPTH - r_count;

endmodule

`default_nettype wire

// File: tb/tb_rob_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : tb_rob_alloc_ctrl
// Purpose  : Directed self-checking bench for rob_alloc_ctrl (ROB=2, 8 entries).
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rob_alloc_ctrl;

  logic       clk;
  logic       reset_n;
  logic       alloc_req;
  logic       commit_valid;
  logic       flush;
  logic [2:0] alloc_tag;
  logic       alloc_grant;
  logic       rob_full;
  logic       rob_empty;
  logic [2:0] commit_tag;
  logic [3:0] free_count;
`ifdef ROB_ALLOC_PERF_EN
  logic [15:0] full_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rob_alloc_ctrl #(.ROB(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alloc_req    (alloc_req),
    .commit_valid (commit_valid),
    .flush        (flush),
    .alloc_tag    (alloc_tag),
    .alloc_grant  (alloc_grant),
    .rob_full     (rob_full),
    .rob_empty    (rob_empty),
    .commit_tag   (commit_tag),
    .free_count   (free_count)
`ifdef ROB_ALLOC_PERF_EN
    ,
    .full_cycles  (full_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; alloc_req = 1'b1; commit_valid = 1'b0; flush = 1'b0;
    #3;
    n_checks++;
    if (alloc_tag !== 3'd0 || commit_tag !== 3'd0 || rob_full !== 1'b0 ||
        rob_empty !== 1'b1 || free_count !== 4'd8) begin
      n_fail++;
      $display("FAIL reset_state: tag=%0d ctag=%0d full=%b empty=%b free=%0d, want 0 0 0 1 8",
               alloc_tag, commit_tag, rob_full, rob_empty, free_count);
    end
    n_checks++;
    if (alloc_grant !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_grant: got %b want 1", alloc_grant);
    end
    alloc_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      alloc_req = 1'b1;
      #1;
      n_checks++;
      if (alloc_grant !== 1'b1 || alloc_tag !== 3'(i)) begin
        n_fail++;
        $display("FAIL fill_grant[%0d]: grant=%b tag=%0d want 1 %0d", i, alloc_grant, alloc_tag, i);
      end
      tick();
    end
    #1;
    n_checks++;
    if (rob_full !== 1'b1 || free_count !== 4'd0 || alloc_grant !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b free=%0d grant=%b want 1 0 0", rob_full, free_count, alloc_grant);
    end
    alloc_req = 1'b0;
  endtask

  task automatic test_full_commit();
    alloc_req = 1'b1; commit_valid = 1'b1;
    #1;
    n_checks++;
    if (alloc_grant !== 1'b0 || commit_tag !== 3'd0) begin
      n_fail++;
      $display("FAIL full_commit_same: grant=%b ctag=%0d want 0 0", alloc_grant, commit_tag);
    end
    tick();
    commit_valid = 1'b0;
    #1;
    n_checks++;
    if (commit_tag !== 3'd1 || rob_full !== 1'b0 || free_count !== 4'd1 ||
        alloc_grant !== 1'b1 || alloc_tag !== 3'd0) begin
      n_fail++;
      $display("FAIL full_commit_next: ctag=%0d full=%b free=%0d grant=%b tag=%0d want 1 0 1 1 0",
               commit_tag, rob_full, free_count, alloc_grant, alloc_tag);
    end
    tick();
    alloc_req = 1'b0;
    #1;
    n_checks++;
    if (rob_full !== 1'b1 || alloc_tag !== 3'd1) begin
      n_fail++;
      $display("FAIL full_commit_refill: full=%b tag=%0d want 1 1", rob_full, alloc_tag);
    end
  endtask

  task automatic test_back_to_back();
    // Drain 5 to reach count 3: head 1 -> 6, tail stays 1.
    commit_valid = 1'b1;
    repeat (5) tick();
    commit_valid = 1'b0;
    #1;
    n_checks++;
    if (free_count !== 4'd5 || commit_tag !== 3'd6) begin
      n_fail++;
      $display("FAIL b2b_setup: free=%0d ctag=%0d want 5 6", free_count, commit_tag);
    end
    alloc_req = 1'b1; commit_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (alloc_grant !== 1'b1 || free_count !== 4'd5) begin
        n_fail++;
        $display("FAIL b2b_cycle[%0d]: grant=%b free=%0d want 1 5", i, alloc_grant, free_count);
      end
      tick();
    end
    alloc_req = 1'b0; commit_valid = 1'b0;
    #1;
    n_checks++;
    if (alloc_tag !== 3'd3 || commit_tag !== 3'd0 || free_count !== 4'd5) begin
      n_fail++;
      $display("FAIL b2b_end: tag=%0d ctag=%0d free=%0d want 3 0 5", alloc_tag, commit_tag, free_count);
    end
  endtask

  task automatic test_flush();
    alloc_req = 1'b1;
    repeat (2) tick();
    flush = 1'b1;
    #1;
    n_checks++;
    if (alloc_grant !== 1'b0 || free_count !== 4'd3) begin
      n_fail++;
      $display("FAIL flush_cycle: grant=%b free=%0d want 0 3", alloc_grant, free_count);
    end
    tick();
    flush = 1'b0;
    #1;
    n_checks++;
    if (rob_full !== 1'b1 || alloc_grant !== 1'b0 || alloc_tag !== 3'd0 ||
        commit_tag !== 3'd0 || free_count !== 4'd8 || rob_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: full=%b grant=%b tag=%0d ctag=%0d free=%0d empty=%b want 1 0 0 0 8 1",
               rob_full, alloc_grant, alloc_tag, commit_tag, free_count, rob_empty);
    end
    tick();
    #1;
    n_checks++;
    if (rob_full !== 1'b0 || alloc_grant !== 1'b1 || alloc_tag !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_resume: full=%b grant=%b tag=%0d want 0 1 0", rob_full, alloc_grant, alloc_tag);
    end
    tick();
    alloc_req = 1'b0; commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic test_empty_commit();
    commit_valid = 1'b1;
    #1;
    n_checks++;
    if (rob_empty !== 1'b1 || commit_tag !== 3'd1) begin
      n_fail++;
      $display("FAIL empty_pre: empty=%b ctag=%0d want 1 1", rob_empty, commit_tag);
    end
    repeat (2) tick();
    commit_valid = 1'b0;
    #1;
    n_checks++;
    if (commit_tag !== 3'd1 || rob_empty !== 1'b1 || free_count !== 4'd8) begin
      n_fail++;
      $display("FAIL empty_commit: ctag=%0d empty=%b free=%0d want 1 1 8", commit_tag, rob_empty, free_count);
    end
  endtask

  task automatic test_reset_mid();
    alloc_req = 1'b1;
    repeat (3) tick();
    alloc_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (alloc_tag !== 3'd0 || commit_tag !== 3'd0 || rob_full !== 1'b0 ||
        rob_empty !== 1'b1 || free_count !== 4'd8) begin
      n_fail++;
      $display("FAIL reset_mid: tag=%0d ctag=%0d full=%b empty=%b free=%0d want 0 0 0 1 8",
               alloc_tag, commit_tag, rob_full, rob_empty, free_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

`ifdef ROB_ALLOC_PERF_EN
  task automatic test_perf();
    alloc_req = 1'b1;
    repeat (8) tick();
    repeat (20) tick();
    alloc_req = 1'b0;
    #1;
    n_checks++;
    if (full_cycles !== 16'd20) begin
      n_fail++;
      $display("FAIL perf_count: got %0d want 20", full_cycles);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (full_cycles !== 16'd0 || rob_full !== 1'b0 || free_count !== 4'd8) begin
      n_fail++;
      $display("FAIL perf_reset: cycles=%0d full=%b free=%0d want 0 0 8", full_cycles, rob_full, free_count);
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_full_commit();
    test_back_to_back();
    test_flush();
    test_empty_commit();
    test_reset_mid();
`ifdef ROB_ALLOC_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
